// File: rtl/key_search_if.sv
// Scheduler <-> key-search-core bus: work grants, broadcast halt and key-hit reporting.
// master = scheduler side, slave = core side.
interface key_search_if #(
    parameter int NUM_CORES = 4
) ();
    logic [NUM_CORES-1:0]    core_req;
    logic [NUM_CORES-1:0]    core_grant;
    logic [23:0]             core_base;
    logic [23:0]             core_last;
    logic                    core_halt;
    logic [NUM_CORES-1:0]    core_hit;
    logic [24*NUM_CORES-1:0] core_hit_key;

    modport master (
        input  core_req, core_hit, core_hit_key,
        output core_grant, core_base, core_last, core_halt
    );

    modport slave (
        output core_req, core_hit, core_hit_key,
        input  core_grant, core_base, core_last, core_halt
    );
endinterface

// File: rtl/key_search_scheduler.sv
// Round-robin chunk dispatcher for the 22-bit RC4 key search; halts all cores on the first hit.
// Optional feature macro: KEY_SEARCH_PROGRESS_EN enables the saturating chunks_granted counter.
module key_search_scheduler #(
    parameter int          NUM_CORES  = 4,
    parameter int          CHUNK_LOG2 = 10,
    parameter logic [23:0] KEY_MAX    = 24'h3FFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [23:0] found_key,
    output logic [2:0]  found_core,
    output logic [12:0] chunks_granted,
    key_search_if.master bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DISPATCH = 3'd1,
        DRAIN    = 3'd2,
        HALT     = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [24:0] CHUNK_SIZE = 25'd1 << CHUNK_LOG2;
    localparam logic [24:0] CHUNK_MASK = CHUNK_SIZE - 25'd1;

    state_t                 state_r, state_s;
    logic [24:0]            next_base_r;
    logic [2:0]             rr_ptr_r;
    logic [NUM_CORES-1:0]   core_grant_r;
    logic [23:0]            core_base_r, core_last_r;
    logic                   found_r;
    logic [23:0]            found_key_r;
    logic [2:0]             found_core_r;
    logic                   busy_r, done_r, core_halt_r;
    logic                   busy_s, done_s, core_halt_s;

    logic [7:0]             elig8_s, hit8_s, onehot8_s;
    logic [3:0]             scan_idx_s;
    logic                   pick_valid_s;
    logic [2:0]             pick_idx_s, hit_idx_s, rr_next_s;
    logic                   hit_any_s, all_idle_s;
    logic [23:0]            hit_keys_s [8];
    logic [24:0]            last_full_s;
    logic [23:0]            chunk_last_s;
    logic                   is_last_chunk_s;
    logic                   start_take_s, hit_take_s, grant_fire_s;

    // Request/hit decode; the previous grant is masked so no core is granted twice in a row.
    always_comb begin
        elig8_s = 8'd0;
        hit8_s  = 8'd0;
        elig8_s[NUM_CORES-1:0] = bus.core_req & ~core_grant_r;
        hit8_s[NUM_CORES-1:0]  = bus.core_hit;
        for (int i = 0; i < 8; i++) begin
            hit_keys_s[i] = (i < NUM_CORES) ? bus.core_hit_key[24*i +: 24] : 24'd0;
        end
        hit_any_s  = |bus.core_hit;
        all_idle_s = &bus.core_req;
    end

    // Round-robin pick (downward scan so the entry nearest rr_ptr wins) and lowest-index hit.
    always_comb begin
        pick_idx_s = 3'd0;
        scan_idx_s = 4'd0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            scan_idx_s = {1'b0, rr_ptr_r} + 4'(k);
            scan_idx_s = (scan_idx_s >= 4'(NUM_CORES)) ? scan_idx_s - 4'(NUM_CORES) : scan_idx_s;
            pick_idx_s = elig8_s[scan_idx_s[2:0]] ? scan_idx_s[2:0] : pick_idx_s;
        end
        pick_valid_s = |elig8_s;
        rr_next_s    = (pick_idx_s == 3'(NUM_CORES - 1)) ? 3'd0 : pick_idx_s + 3'd1;
        onehot8_s    = 8'd1 << pick_idx_s;
        hit_idx_s    = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            hit_idx_s = hit8_s[i] ? 3'(i) : hit_idx_s;
        end
    end

    // Chunk bounds, clipped to the end of the key space.
    always_comb begin
        last_full_s     = next_base_r + CHUNK_MASK;
        chunk_last_s    = (last_full_s > {1'b0, KEY_MAX}) ? KEY_MAX : last_full_s[23:0];
        is_last_chunk_s = (chunk_last_s == KEY_MAX);
        start_take_s    = ((state_r == IDLE) || (state_r == DONE)) && start;
        hit_take_s      = ((state_r == DISPATCH) || (state_r == DRAIN)) && hit_any_s;
        grant_fire_s    = (state_r == DISPATCH) && pick_valid_s && !hit_any_s;
    end

    // State register plus registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            core_halt_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            core_halt_r <= core_halt_s;
        end
    end

    // Next-state logic; a hit pre-empts any grant in the same cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:     state_s = start ? DISPATCH : IDLE;
            DONE:     state_s = start ? DISPATCH : DONE;
            DISPATCH: begin
                if (hit_any_s) state_s = HALT;
                else if (grant_fire_s && is_last_chunk_s) state_s = DRAIN;
                else state_s = DISPATCH;
            end
            DRAIN: begin
                if (hit_any_s) state_s = HALT;
                else if (all_idle_s) state_s = DONE;
                else state_s = DRAIN;
            end
            HALT:     state_s = all_idle_s ? DONE : HALT;
            default:  state_s = IDLE;
        endcase
    end

    // Status decode of the upcoming state, registered alongside it.
    always_comb begin
        busy_s      = 1'b0;
        done_s      = 1'b0;
        core_halt_s = 1'b0;
        case (state_s)
            DISPATCH, DRAIN: busy_s = 1'b1;
            HALT: begin
                busy_s      = 1'b1;
                core_halt_s = 1'b1;
            end
            DONE:    done_s = 1'b1;
            default: busy_s = 1'b0;
        endcase
    end

    // Grant, dispatch pointer and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_grant_r <= '0;
            core_base_r  <= 24'd0;
            core_last_r  <= 24'd0;
            next_base_r  <= 25'd0;
            rr_ptr_r     <= 3'd0;
            found_r      <= 1'b0;
            found_key_r  <= 24'd0;
            found_core_r <= 3'd0;
        end else if (start_take_s) begin
            core_grant_r <= '0;
            next_base_r  <= 25'd0;
            rr_ptr_r     <= 3'd0;
            found_r      <= 1'b0;
            found_key_r  <= 24'd0;
            found_core_r <= 3'd0;
        end else if (hit_take_s) begin
            core_grant_r <= '0;
            found_r      <= 1'b1;
            found_key_r  <= hit_keys_s[hit_idx_s];
            found_core_r <= hit_idx_s;
        end else if (grant_fire_s) begin
            core_grant_r <= onehot8_s[NUM_CORES-1:0];
            core_base_r  <= next_base_r[23:0];
            core_last_r  <= chunk_last_s;
            next_base_r  <= next_base_r + CHUNK_SIZE;
            rr_ptr_r     <= rr_next_s;
        end else begin
            core_grant_r <= '0;
        end
    end

`ifdef KEY_SEARCH_PROGRESS_EN
    logic [12:0] chunks_r;

    // Saturating per-run grant counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) chunks_r <= 13'd0;
        else if (start_take_s) chunks_r <= 13'd0;
        else if (grant_fire_s && (chunks_r != 13'h1FFF)) chunks_r <= chunks_r + 13'd1;
        else chunks_r <= chunks_r;
    end
    assign chunks_granted = chunks_r;
`else
    assign chunks_granted = 13'd0;
`endif

    assign busy           = busy_r;
    assign done           = done_r;
    assign found          = found_r;
    assign found_key      = found_key_r;
    assign found_core     = found_core_r;
    assign bus.core_grant = core_grant_r;
    assign bus.core_base  = core_base_r;
    assign bus.core_last  = core_last_r;
    assign bus.core_halt  = core_halt_r;
endmodule

// File: tb/tb_key_search_scheduler.sv
// Directed bench for key_search_scheduler (4 cores, 1M-key chunks => 4 chunks per run).
module tb_key_search_scheduler;
    logic        clk;
    logic        reset;
    logic        start;
    logic        busy, done, found;
    logic [23:0] found_key;
    logic [2:0]  found_core;
    logic [12:0] chunks_granted;
    int          errors;
    int          checks;

`ifdef KEY_SEARCH_PROGRESS_EN
    localparam int EXP_CHUNKS = 4;
`else
    localparam int EXP_CHUNKS = 0;
`endif

    key_search_if #(.NUM_CORES(4)) bus ();

    key_search_scheduler #(
        .NUM_CORES (4),
        .CHUNK_LOG2(20),
        .KEY_MAX   (24'h3FFFFF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .found         (found),
        .found_key     (found_key),
        .found_core    (found_core),
        .chunks_granted(chunks_granted),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] g, input logic [23:0] b,
                             input logic [23:0] l);
        chk({tag, "_grant"}, 32'(bus.core_grant), 32'(g));
        chk({tag, "_base"},  32'(bus.core_base),  32'(b));
        chk({tag, "_last"},  32'(bus.core_last),  32'(l));
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        start  = 1'b0;
        bus.core_req     = 4'b0000;
        bus.core_hit     = 4'b0000;
        bus.core_hit_key = 96'd0;
        #12;
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_grant", 32'(bus.core_grant), 32'd0);
        chk("rst_halt",  32'(bus.core_halt), 32'd0);
        reset = 1'b0;
        tick();

        // Reset in the middle of dispatching
        pulse_start();
        chk("d1_busy", 32'(busy), 32'd1);
        bus.core_req = 4'b1111;
        tick();
        chk_grant("d1_g0", 4'b0001, 24'h000000, 24'h0FFFFF);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy",  32'(busy), 32'd0);
        chk("mid_rst_grant", 32'(bus.core_grant), 32'd0);
        chk("mid_rst_base",  32'(bus.core_base), 32'd0);
        chk("mid_rst_last",  32'(bus.core_last), 32'd0);
        #1 reset = 1'b0;
        tick();
        tick();
        chk("post_rst_grant", 32'(bus.core_grant), 32'd0);
        chk("post_rst_busy",  32'(busy), 32'd0);

        // Full run, no key found, all cores requesting
        pulse_start();
        chk("nf_busy", 32'(busy), 32'd1);
        tick();
        chk_grant("nf_g0", 4'b0001, 24'h000000, 24'h0FFFFF);
        tick();
        chk_grant("nf_g1", 4'b0010, 24'h100000, 24'h1FFFFF);
        tick();
        chk_grant("nf_g2", 4'b0100, 24'h200000, 24'h2FFFFF);
        tick();
        chk_grant("nf_g3", 4'b1000, 24'h300000, 24'h3FFFFF);
        chk("nf_drain_busy", 32'(busy), 32'd1);
        tick();
        chk("nf_drain_grant", 32'(bus.core_grant), 32'd0);
        chk("nf_done",   32'(done), 32'd1);
        chk("nf_busy0",  32'(busy), 32'd0);
        chk("nf_found",  32'(found), 32'd0);
        chk("nf_chunks", 32'(chunks_granted), 32'(EXP_CHUNKS));

        // Hit from core 2 during dispatch
        pulse_start();
        tick();
        chk_grant("hit_g0", 4'b0001, 24'h000000, 24'h0FFFFF);
        bus.core_req = 4'b0000;
        bus.core_hit = 4'b0100;
        bus.core_hit_key = {24'h0, 24'h000249, 24'h0, 24'h0};
        tick();
        bus.core_hit = 4'b0000;
        chk("hit_halt",  32'(bus.core_halt), 32'd1);
        chk("hit_busy",  32'(busy), 32'd1);
        chk("hit_grant", 32'(bus.core_grant), 32'd0);
        chk("hit_key",   32'(found_key), 32'h000249);
        bus.core_hit = 4'b0001;
        bus.core_hit_key = {24'h0, 24'h0, 24'h0, 24'h111111};
        tick();
        bus.core_hit = 4'b0000;
        chk("halt_hold",      32'(bus.core_halt), 32'd1);
        chk("halt_ignore_hit", 32'(found_key), 32'h000249);
        bus.core_req = 4'b1111;
        tick();
        chk("hit_done",     32'(done), 32'd1);
        chk("hit_halt_off", 32'(bus.core_halt), 32'd0);
        chk("hit_found",    32'(found), 32'd1);
        chk("hit_key_done", 32'(found_key), 32'h000249);
        chk("hit_core",     32'(found_core), 32'd2);

        // Restart from DONE, then round-robin between cores 1 and 3
        bus.core_req = 4'b0000;
        pulse_start();
        chk("rs_found",  32'(found), 32'd0);
        chk("rs_key",    32'(found_key), 32'd0);
        chk("rs_chunks", 32'(chunks_granted), 32'd0);
        chk("rs_busy",   32'(busy), 32'd1);
        bus.core_req = 4'b1010;
        tick();
        chk_grant("rr_g0", 4'b0010, 24'h000000, 24'h0FFFFF);
        tick();
        chk_grant("rr_g1", 4'b1000, 24'h100000, 24'h1FFFFF);
        tick();
        chk_grant("rr_g2", 4'b0010, 24'h200000, 24'h2FFFFF);
        tick();
        chk_grant("rr_g3", 4'b1000, 24'h300000, 24'h3FFFFF);
        tick();
        chk("rr_drain_wait", 32'(busy), 32'd1);
        bus.core_req = 4'b1111;
        tick();
        chk("rr_done",   32'(done), 32'd1);
        chk("rr_chunks", 32'(chunks_granted), 32'(EXP_CHUNKS));

        // Simultaneous hits from cores 1 and 3 with a pending request
        bus.core_req = 4'b0000;
        pulse_start();
        bus.core_req = 4'b0001;
        bus.core_hit = 4'b1010;
        bus.core_hit_key = {24'h3B0000, 24'h0, 24'h0A0001, 24'h0};
        tick();
        bus.core_hit = 4'b0000;
        chk("sim_grant", 32'(bus.core_grant), 32'd0);
        chk("sim_halt",  32'(bus.core_halt), 32'd1);
        chk("sim_core",  32'(found_core), 32'd1);
        chk("sim_key",   32'(found_key), 32'h0A0001);
        bus.core_req = 4'b1111;
        tick();
        chk("sim_done",  32'(done), 32'd1);
        chk("sim_found", 32'(found), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
